uart_tx_port: RTL and testbench
===============================

# uart_tx_port

Memory-mapped UART transmitter on the CPU data bus, beside the RAM/ROM/IO-port decoder. Bytes written to its data register go into an 8-entry FIFO and are serialised 8N1 on `tx`. A status register lets the CPU poll for space. Reads use the same protocol as the rest of the bus: data appears one clock tick after the address is valid, and the output is high-impedance when the block is not selected.

## Interface
Parameters:
- `BASE_ADDR`, 16'h8401: data register; status register is at `BASE_ADDR+1`.
- `CLKS_PER_BIT`, 217: clocks per serial bit; must be ≥2.
- `FIFO_DEPTH`, 8: power of two, ≥2.

Ports:
- `clk` input 1: the single clock.
- `reset` input 1: synchronous, active-high. One clock; reset is synchronous and active-high.
- `addr` input 16: bus address.
- `data_in` input 8: write data.
- `data_out` output 8: read data; `8'bZ` unless selected on the previous cycle.
- `write_enable` input 1: bus write strobe, sampled at the rising edge.
- `tx` output 1: serial line, idle high.

## Operation
- **Decode.**
  - `sel_data` = (`addr` == `BASE_ADDR`).
  - `sel_stat` = (`addr` == `BASE_ADDR+1`).
- **Write to data register.** Pushes `data_in` when `write_enable && sel_data`.
  - The push is accepted if count < `FIFO_DEPTH`, or if a pop occurs on the same edge.
  - Otherwise the byte is dropped and sticky `overflow` is set.
- **Write to status register.** Ignored.
- **Read of data register.** Returns 8'h00.
- **Status byte:**
  - bit0 `busy`: FSM not IDLE.
  - bit1 `full`: count == `FIFO_DEPTH`.
  - bit2 `empty`: count == 0.
  - bit3 `overflow`.
  - bits[7:4] `count`, saturating at 15.
- **Read capture.** `data_out` is registered: the value captured at edge E is driven during cycle E+1.
  - The select flags are registered alongside the data.
  - `overflow` clears on any edge where `sel_stat` is high and `write_enable` is low.
  - If an overflow occurs on the same edge, set wins.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE: if count>0, pop into the shift register, `tx`<=0, and go to START with the timer loaded to `CLKS_PER_BIT-1`.
  - START: when the timer reaches 0 → DATA, bit index 0, `tx`<=shift[0].
  - DATA: when the timer reaches 0 → shift right and increment the index. After bit 7 completes → STOP with `tx`<=1.
  - STOP: when the timer reaches 0 → if count>0, pop and go to START directly (`tx`<=0, no idle cycle); otherwise go to IDLE.
- **Bit order.** LSB first.
- **Frame length.** Exactly 10·`CLKS_PER_BIT` clocks.
- **FIFO pointers.** Wrap modulo `FIFO_DEPTH`. The count width is log2(`FIFO_DEPTH`)+1.

## Timing
- **Reset values:**
  - `tx`=1.
  - FSM=IDLE.
  - FIFO empty, count=0.
  - `overflow`=0.
  - Registered selects=0, so `data_out`=Z.
  - Timer and shift register = 0.
- **Reset mid-frame.** Aborts the frame. `tx` returns high on the next edge and FIFO contents are discarded.
- **Write latency.** A write at edge E0 with the FSM idle and FIFO empty gives `tx` falling at edge E0+1.
- **Status visibility.** A status read issued at E0+1 shows `empty`=1 and `busy`=1, because the pop happens at E0+1.
- **Back-to-back frames.** A write landing on the same edge as a STOP-end pop is queued; if it is the only byte, it starts at the next IDLE edge.
- **Read latency.** Exactly 1 cycle; there are no wait states.

## Structure
- **Package `uart_pkg`:**
  - FSM state enum.
  - Register offsets `UART_REG_DATA=0` and `UART_REG_STAT=1`.
  - Status bit positions.
- **Sub-module `sync_fifo`.** Parameterised width and depth; push, pop, dout, count, full, empty; synchronous reset.
  - Its `dout` is combinational from the read pointer, so the pop and load happen on the same edge.
- **Top level.** Holds the decode, registered read mux, FSM, bit timer and shifter.

## Test plan
1. **Single byte.** Set `CLKS_PER_BIT`=4 and write 8'hA5 to 16'h8401 → `tx` shows 0,1,0,1,0,0,1,0,1,1, each level held 4 clocks. Start bit falls 1 edge after the write; total frame is 40 clocks.
2. **Fill FIFO.** While busy, write 9 bytes → status read returns `full`=1, `overflow`=1, `count`=8. A second status read shows `overflow`=0. The ninth byte is never transmitted.
3. **Back-to-back.** Write 8'h00 then 8'hFF on consecutive cycles → two frames with no idle gap between the first stop bit and the second start bit.
4. **Read protocol.**
   - Address 16'h8402 at cycle N → status value on `data_out` in cycle N+1.
   - Address 16'h0000 at cycle N → `data_out` is Z in cycle N+1.
   - Address 16'h8401 → 8'h00.
5. **Reset mid-frame.** Assert `reset` during DATA bit 3 → `tx`=1 next edge, status reads 8'h04, and no further frame is sent.
6. **Simultaneous events.** Push on the same edge as a STOP-end pop with the FIFO full → push accepted and count stays 8. A status read on the same edge as an overflow → `overflow` remains 1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared state encoding and register map for the memory-mapped UART transmitter.
package uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } uart_state_e;

   localparam logic [15:0] UART_REG_DATA = 16'd0;
   localparam logic [15:0] UART_REG_STAT = 16'd1;

   localparam int STAT_BUSY    = 0;
   localparam int STAT_FULL    = 1;
   localparam int STAT_EMPTY   = 2;
   localparam int STAT_OVF     = 3;
   localparam int STAT_CNT_LSB = 4;

   // The status nibble has room for 0..15 only.
   function automatic logic [3:0] sat_count(input logic [31:0] c);
      return (c > 32'd15) ? 4'hF : c[3:0];
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a combinational read port, so a pop and the consumer's
// load of dout happen on the same edge.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   // A full FIFO still takes a byte when a slot frees on the same edge.
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/uart_tx_port.sv
// Bus-mapped 8N1 UART transmitter: data/status registers, FIFO, bit timer and shifter.
//   state    | meaning
//   ST_IDLE  | line high, waiting for a queued byte
//   ST_START | driving the start bit (low)
//   ST_DATA  | shifting out data bits, LSB first
//   ST_STOP  | driving the stop bit (high), then chain or idle
module uart_tx_port #(
   parameter logic [15:0] BASE_ADDR    = 16'h8401,
   parameter int          CLKS_PER_BIT = 217,
   parameter int          FIFO_DEPTH   = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] addr,
   input  logic [7:0]  data_in,
   output logic [7:0]  data_out,
   input  logic        write_enable,
   output logic        tx
);
   import uart_pkg::*;

   localparam int            CW     = $clog2(FIFO_DEPTH) + 1;
   localparam int            TW     = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0] T_LOAD = TW'(CLKS_PER_BIT - 1);

   logic          sel_data, sel_stat, push, pop, overflow, sel_q;
   logic [7:0]    fifo_dout, status, rdata_q;
   logic [CW-1:0] fifo_count;
   logic          fifo_full, fifo_empty;

   uart_state_e   state, state_nxt;
   logic [TW-1:0] timer, timer_nxt;
   logic [7:0]    shift, shift_nxt;
   logic [2:0]    bit_idx, bit_idx_nxt;
   logic          tx_nxt;

   assign sel_data = (addr == BASE_ADDR + UART_REG_DATA);
   assign sel_stat = (addr == BASE_ADDR + UART_REG_STAT);
   assign push     = write_enable && sel_data;

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (data_in),
      .dout  (fifo_dout),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         timer   <= '0;
         shift   <= '0;
         bit_idx <= '0;
         tx      <= 1'b1;
      end else begin
         state   <= state_nxt;
         timer   <= timer_nxt;
         shift   <= shift_nxt;
         bit_idx <= bit_idx_nxt;
         tx      <= tx_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      timer_nxt   = timer;
      shift_nxt   = shift;
      bit_idx_nxt = bit_idx;
      tx_nxt      = tx;
      pop         = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop       = 1'b1;
               shift_nxt = fifo_dout;
               tx_nxt    = 1'b0;
               timer_nxt = T_LOAD;
               state_nxt = ST_START;
            end
         end
         ST_START: begin
            if (timer == '0) begin
               state_nxt   = ST_DATA;
               bit_idx_nxt = '0;
               tx_nxt      = shift[0];
               timer_nxt   = T_LOAD;
            end else begin
               timer_nxt = timer - TW'(1);
            end
         end
         ST_DATA: begin
            if (timer == '0) begin
               timer_nxt = T_LOAD;
               if (bit_idx == 3'd7) begin
                  state_nxt = ST_STOP;
                  tx_nxt    = 1'b1;
               end else begin
                  shift_nxt   = shift >> 1;
                  bit_idx_nxt = bit_idx + 3'd1;
                  tx_nxt      = shift[1];
               end
            end else begin
               timer_nxt = timer - TW'(1);
            end
         end
         ST_STOP: begin
            if (timer == '0) begin
               // Chain straight into the next start bit when more data is queued.
               if (!fifo_empty) begin
                  pop       = 1'b1;
                  shift_nxt = fifo_dout;
                  tx_nxt    = 1'b0;
                  timer_nxt = T_LOAD;
                  state_nxt = ST_START;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end else begin
               timer_nxt = timer - TW'(1);
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      status                       = '0;
      status[STAT_BUSY]            = (state != ST_IDLE);
      status[STAT_FULL]            = fifo_full;
      status[STAT_EMPTY]           = fifo_empty;
      status[STAT_OVF]             = overflow;
      status[STAT_CNT_LSB +: 4]    = sat_count(32'(fifo_count));
   end

   // Sticky overflow: a dropped byte on the same edge as a status read keeps it set.
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow <= 1'b0;
      end else if (push && fifo_full && !pop) begin
         overflow <= 1'b1;
      end else if (sel_stat && !write_enable) begin
         overflow <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sel_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         sel_q   <= sel_data || sel_stat;
         rdata_q <= sel_stat ? status : 8'h00;
      end
   end

   assign data_out = sel_q ? rdata_q : 8'bz;

endmodule

// File: tb/tb_uart_tx_port.sv
// Scoreboard bench: writes queue expected bytes, a line monitor decodes frames and checks them.
module tb_uart_tx_port;
   localparam int          CPB  = 4;
   localparam logic [15:0] BASE = 16'h8401;
   localparam logic [15:0] STAT = 16'h8402;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        write_enable = 1'b0;
   logic [15:0] addr = 16'h0000;
   logic [7:0]  data_in = 8'h00;
   wire  [7:0]  data_bus;
   wire         tx;

   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   bit   mon_en = 1'b1;
   logic [7:0] exp_q[$];
   int   starts[$];

   for (genvar g = 0; g < 8; g++) begin : g_pu
      pullup (data_bus[g]);
   end

   uart_tx_port #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .addr         (addr),
      .data_in      (data_in),
      .data_out     (data_bus),
      .write_enable (write_enable),
      .tx           (tx)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   function automatic logic [7:0] stat_byte(input bit busy, input bit full, input bit empty,
                                            input bit ovf, input int cnt);
      logic [3:0] c;
      c = 4'((cnt > 15) ? 15 : cnt);
      return {c, ovf, empty, full, busy};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   task automatic write_byte(input logic [15:0] a, input logic [7:0] b);
      addr = a; data_in = b; write_enable = 1'b1;
      @(posedge clk); #1;
      write_enable = 1'b0; addr = 16'h0000;
   endtask

   task automatic rd(input logic [15:0] a, output logic [7:0] v);
      addr = a; write_enable = 1'b0;
      @(posedge clk); #1;
      v = data_bus; addr = 16'h0000;
   endtask

   task automatic wait_idle(input string name);
      logic [7:0] v;
      bit done;
      done = 1'b0;
      v = 8'h00;
      for (int i = 0; i < 3000 && !done; i++) begin
         rd(STAT, v);
         if (v[0] == 1'b0 && v[2] == 1'b1) done = 1'b1;
      end
      check(name, {31'd0, done}, 32'd1);
   endtask

   initial begin : monitor
      logic [9:0] lv;
      logic [7:0] got, want;
      forever begin
         @(negedge clk);
         if (mon_en && tx === 1'b0) begin
            starts.push_back(cyc);
            for (int k = 0; k < 10; k++) begin
               repeat ((k == 0) ? CPB / 2 : CPB) @(negedge clk);
               lv[k] = tx;
            end
            got = lv[8:1];
            checks++;
            if (lv[0] !== 1'b0 || lv[9] !== 1'b1) begin
               errors++;
               $display("FAIL frame_fmt: start/stop got %b/%b required 0/1", lv[0], lv[9]);
            end
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_frame: got byte %02h required no frame", got);
            end else begin
               want = exp_q.pop_front();
               if (got !== want) begin
                  errors++;
                  $display("FAIL frame_data: got %02h required %02h", got, want);
               end
            end
         end
      end
   end

   initial begin : stimulus
      logic [7:0] v, b;
      logic [9:0] fr;
      logic [7:0] fb[10];
      int bad, n, gap;

      repeat (3) @(posedge clk);
      #1;
      check("rst_tx", {31'd0, tx}, 32'd1);
      reset = 1'b0;
      rd(STAT, v);
      check("rst_status", v, stat_byte(0, 0, 1, 0, 0));
      rd(16'h0000, v);
      check("init_hiz", v, 8'hFF);

      // single byte waveform and latency
      write_byte(BASE, 8'hA5);
      exp_q.push_back(8'hA5);
      fr = {1'b1, 8'hA5, 1'b0};
      bad = 0;
      for (int i = 0; i < 41; i++) begin
         @(posedge clk); #1;
         if (tx !== ((i < 40) ? fr[i / CPB] : 1'b1)) bad++;
      end
      check("t1_wave_bad_samples", bad, 0);

      // read protocol
      rd(BASE, v);
      check("rd_data_reg", v, 8'h00);
      rd(16'h0000, v);
      check("rd_unselected_hiz", v, 8'hFF);
      write_byte(STAT, 8'hFF);
      rd(STAT, v);
      check("rd_status_after_stat_write", v, stat_byte(0, 0, 1, 0, 0));
      rd(16'h8403, v);
      check("rd_next_addr_hiz", v, 8'hFF);

      // status one cycle after a write: byte already popped
      write_byte(BASE, 8'h3C);
      exp_q.push_back(8'h3C);
      @(posedge clk); #1;
      rd(STAT, v);
      check("status_after_pop", v, stat_byte(1, 0, 1, 0, 0));
      wait_idle("idle_t_vis");

      // fill FIFO while busy, overflow, then push on the stop-end pop edge
      for (int i = 0; i < 10; i++) fb[i] = 8'($urandom_range(0, 255));
      write_byte(BASE, fb[0]);
      exp_q.push_back(fb[0]);
      for (int i = 1; i < 10; i++) begin
         write_byte(BASE, fb[i]);
         if (i <= 8) exp_q.push_back(fb[i]);
      end
      rd(STAT, v);
      check("fill_status", v, stat_byte(1, 1, 0, 1, 8));
      rd(STAT, v);
      check("fill_status_ovf_cleared", v, stat_byte(1, 1, 0, 0, 8));
      repeat (29) @(posedge clk);
      #1;
      b = 8'($urandom_range(0, 255));
      write_byte(BASE, b);
      exp_q.push_back(b);
      rd(STAT, v);
      check("push_on_pop_edge_full", v, stat_byte(1, 1, 0, 0, 8));
      wait_idle("idle_fill");

      // back-to-back frames
      starts.delete();
      write_byte(BASE, 8'h00);
      write_byte(BASE, 8'hFF);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'hFF);
      wait_idle("idle_b2b");
      check("b2b_frames", starts.size(), 2);
      if (starts.size() >= 2) check("b2b_gap", starts[1] - starts[0], 10 * CPB);

      // reset during data bit 3 (0x52 has bit3 = 0)
      mon_en = 1'b0;
      write_byte(BASE, 8'h52);
      write_byte(BASE, 8'hC3);
      repeat (17) @(posedge clk);
      #1;
      check("pre_reset_bit3", {31'd0, tx}, 32'd0);
      reset = 1'b1;
      @(posedge clk); #1;
      check("reset_tx_high", {31'd0, tx}, 32'd1);
      reset = 1'b0;
      rd(STAT, v);
      check("reset_status", v, 8'h04);
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (tx !== 1'b1) bad++;
      end
      check("reset_no_frame", bad, 0);
      mon_en = 1'b1;

      // randomized bursts
      for (int r = 0; r < 6; r++) begin
         wait_idle("idle_rand");
         n = $urandom_range(1, 8);
         for (int i = 0; i < n; i++) begin
            b = 8'($urandom_range(0, 255));
            write_byte(BASE, b);
            exp_q.push_back(b);
            gap = $urandom_range(0, 2);
            repeat (gap) @(posedge clk);
            #1;
         end
      end
      wait_idle("idle_final");
      repeat (5) @(posedge clk);
      check("all_frames_sent", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
